// File: rtl/video_timing_gen_if.sv
// Video raster bundle: control inputs, palette colour in, raster counters, strobes and pin drivers out.
// The generator side uses the master modport; the composer/pin side uses slave.
interface video_timing_gen_if #(
    parameter int CBITS = 4
);
    logic                 enable;
    logic [11:0]          irq_line;
    logic [3*CBITS-1:0]   rgb_data;
    logic [11:0]          x_pos;
    logic [11:0]          y_pos;
    logic                 next_pixel;
    logic                 next_line;
    logic                 next_frame;
    logic                 vblank_pulse;
    logic                 line_irq;
    logic [CBITS-1:0]     vga_r;
    logic [CBITS-1:0]     vga_g;
    logic [CBITS-1:0]     vga_b;
    logic                 vga_hsync;
    logic                 vga_vsync;

    modport master (
        input  enable, irq_line, rgb_data,
        output x_pos, y_pos, next_pixel, next_line, next_frame, vblank_pulse, line_irq,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );

    modport slave (
        output enable, irq_line, rgb_data,
        input  x_pos, y_pos, next_pixel, next_line, next_frame, vblank_pulse, line_irq,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel divider, delayed sync/blank pipe and
// registered RGB/sync output stage.
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIX_DIV    = 1,
    parameter int PIPE_DELAY = 2,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CBITS      = 4
) (
    input  logic               clk,
    input  logic               rst,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [3:0]           div_reg;
    logic [11:0]          x_reg;
    logic [11:0]          y_reg;
    logic                 pix_en;
    logic                 h_last;
    logic [2:0]           flags_cur;   // {hsync, vsync, active}, active-high internally
    logic [2:0]           flags_dly;
    logic [3*CBITS-1:0]   rgb_reg;
    logic                 hsync_reg;
    logic                 vsync_reg;

    // rst gates the strobe so nothing fires while reset is held, even with PIX_DIV=1
    assign pix_en = vid.enable && !rst && (div_reg == 4'(PIX_DIV - 1));
    assign h_last = pix_en && (x_reg == 12'(H_TOTAL - 1));

    assign vid.next_pixel   = pix_en;
    assign vid.next_line    = h_last;
    assign vid.next_frame   = h_last && (y_reg == 12'(V_TOTAL - 2));
    assign vid.vblank_pulse = h_last && (y_reg == 12'(V_ACTIVE - 1));
    assign vid.line_irq     = h_last && (y_reg == vid.irq_line);
    assign vid.x_pos        = x_reg;
    assign vid.y_pos        = y_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
        end else if (!vid.enable) begin
            div_reg <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
        end else begin
            div_reg <= (div_reg == 4'(PIX_DIV - 1)) ? 4'd0 : div_reg + 4'd1;
            if (pix_en) begin
                if (x_reg == 12'(H_TOTAL - 1)) begin
                    x_reg <= '0;
                    y_reg <= (y_reg == 12'(V_TOTAL - 1)) ? 12'd0 : y_reg + 12'd1;
                end else begin
                    x_reg <= x_reg + 12'd1;
                end
            end
        end
    end

    assign flags_cur[2] = (x_reg >= 12'(HS_START)) && (x_reg < 12'(HS_END));
    assign flags_cur[1] = (y_reg >= 12'(VS_START)) && (y_reg < 12'(VS_END));
    assign flags_cur[0] = (x_reg < 12'(H_ACTIVE)) && (y_reg < 12'(V_ACTIVE));

    // Sync/blank flags are delayed to line up with palette latency; stages move only on pixel enables
    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign flags_dly = flags_cur;
        end else begin : g_dly
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic [2:0] stage_reg;
                logic [2:0] stage_in;
                if (gi == 0) begin : g_first
                    assign stage_in = flags_cur;
                end else begin : g_next
                    assign stage_in = g_stage[gi-1].stage_reg;
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg <= '0;
                    end else if (!vid.enable) begin
                        stage_reg <= '0;
                    end else if (pix_en) begin
                        stage_reg <= stage_in;
                    end
                end
            end
            assign flags_dly = g_stage[PIPE_DELAY-1].stage_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_reg   <= '0;
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
        end else if (!vid.enable) begin
            rgb_reg   <= '0;
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
        end else if (pix_en) begin
            rgb_reg   <= flags_dly[0] ? vid.rgb_data : '0;
            hsync_reg <= flags_dly[2] ? HS_POL : ~HS_POL;
            vsync_reg <= flags_dly[1] ? VS_POL : ~VS_POL;
        end
    end

    assign vid.vga_r     = rgb_reg[3*CBITS-1:2*CBITS];
    assign vid.vga_g     = rgb_reg[2*CBITS-1:CBITS];
    assign vid.vga_b     = rgb_reg[CBITS-1:0];
    assign vid.vga_hsync = hsync_reg;
    assign vid.vga_vsync = vsync_reg;
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen on a small raster: the reference model derives
// positions, strobes and pin levels from pixel counts with plain arithmetic.
module tb_video_timing_gen;
    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int PDIV = 2;
    localparam int PDLY = 2;
    localparam bit HPOL = 1'b1;
    localparam bit VPOL = 1'b0;
    localparam int NCYC = 3200;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        nl;
        logic        nf;
        logic        vb;
        logic        irq;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } obs_t;

    logic clk;
    logic rst;
    video_timing_gen_if #(.CBITS(4)) vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .PIX_DIV(PDIV), .PIPE_DELAY(PDLY), .HS_POL(HPOL), .VS_POL(VPOL), .CBITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid(vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t pix_q[$];
    obs_t gap_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: whenever the DUT presents a pixel enable, the oldest pixel expectation is checked;
    // on non-pixel clocks the idle expectation queue is checked instead.
    initial begin
        obs_t got;
        obs_t exp;
        forever begin
            @(negedge clk);
            #1;
            got = '{x: vif.x_pos, y: vif.y_pos, nl: vif.next_line, nf: vif.next_frame,
                    vb: vif.vblank_pulse, irq: vif.line_irq,
                    rgb: {vif.vga_r, vif.vga_g, vif.vga_b}, hs: vif.vga_hsync, vs: vif.vga_vsync};
            n_cmp++;
            if (vif.next_pixel) begin
                if (pix_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pixel_unexpected t=%0t got=%h required=no pixel enable", $time, got);
                end else begin
                    exp = pix_q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL pixel t=%0t got x=%0d y=%0d nl%b nf%b vb%b irq%b rgb=%h hs%b vs%b required x=%0d y=%0d nl%b nf%b vb%b irq%b rgb=%h hs%b vs%b",
                                 $time, got.x, got.y, got.nl, got.nf, got.vb, got.irq, got.rgb, got.hs, got.vs,
                                 exp.x, exp.y, exp.nl, exp.nf, exp.vb, exp.irq, exp.rgb, exp.hs, exp.vs);
                    end
                end
            end else begin
                if (gap_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL idle_unexpected t=%0t got=%h required=pixel enable", $time, got);
                end else begin
                    exp = gap_q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL idle t=%0t got x=%0d y=%0d nl%b nf%b vb%b irq%b rgb=%h hs%b vs%b required x=%0d y=%0d nl%b nf%b vb%b irq%b rgb=%h hs%b vs%b",
                                 $time, got.x, got.y, got.nl, got.nf, got.vb, got.irq, got.rgb, got.hs, got.vs,
                                 exp.x, exp.y, exp.nl, exp.nf, exp.vb, exp.irq, exp.rgb, exp.hs, exp.vs);
                    end
                end
            end
        end
    end

    // Stimulus plus reference model. t = clocks elapsed in the current enabled run,
    // so the pixel index is t/PDIV and the raster position is that index modulo the frame.
    initial begin
        int          t;
        int          p;
        int          idx;
        int          src;
        int          drop_left;
        int          irq_sel;
        int          irq_list[6];
        logic [11:0] pin_rgb;
        logic        pin_hs;
        logic        pin_vs;
        logic        np;
        int          ex;
        int          ey;
        obs_t        e;

        irq_list[0] = VA - 1;   // coincides with vblank_pulse
        irq_list[1] = VT - 2;   // coincides with next_frame
        irq_list[2] = 600;      // never fires
        irq_list[3] = VT;       // just out of range, never fires
        irq_list[4] = 0;
        irq_list[5] = 3;

        rst = 1'b1;
        vif.enable   = 1'b0;
        vif.irq_line = 12'(irq_list[0]);
        vif.rgb_data = 12'hF0A;
        t = 0;
        drop_left = 0;
        irq_sel = 0;
        pin_rgb = '0;
        pin_hs = ~HPOL;
        pin_vs = ~VPOL;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            // reset at start and once mid-frame
            rst = (n < 3) || (n >= 1500 && n < 1503);
            if (n % 520 == 0) begin
                vif.irq_line = 12'(irq_list[irq_sel]);
                irq_sel = (irq_sel + 1) % 6;
            end
            if (drop_left > 0) begin
                drop_left--;
                vif.enable = 1'b0;
            end else if (n > 3 && $urandom_range(0, 399) == 0) begin
                drop_left = int'($urandom_range(0, 4));
                vif.enable = 1'b0;
            end else begin
                vif.enable = (n >= 2);
            end
            vif.rgb_data = ($urandom_range(0, 3) == 0) ? 12'hF0A : 12'($urandom);

            if (rst) begin
                t = 0;
                pin_rgb = '0;
                pin_hs = ~HPOL;
                pin_vs = ~VPOL;
            end

            np  = vif.enable && !rst && (t % PDIV == PDIV - 1);
            p   = t / PDIV;
            idx = p % FRAME;
            ex  = idx % HT;
            ey  = idx / HT;
            e.x   = 12'(ex);
            e.y   = 12'(ey);
            e.nl  = np && (ex == HT - 1);
            e.nf  = e.nl && (ey == VT - 2);
            e.vb  = e.nl && (ey == VA - 1);
            e.irq = e.nl && (ey == int'(vif.irq_line));
            e.rgb = pin_rgb;
            e.hs  = pin_hs;
            e.vs  = pin_vs;
            if (np) pix_q.push_back(e);
            else    gap_q.push_back(e);

            // state after the coming rising edge
            if (!rst) begin
                if (!vif.enable) begin
                    t = 0;
                    pin_rgb = '0;
                    pin_hs = ~HPOL;
                    pin_vs = ~VPOL;
                end else begin
                    if (np) begin
                        src = p - PDLY;
                        if (src < 0) begin
                            pin_rgb = '0;
                            pin_hs = ~HPOL;
                            pin_vs = ~VPOL;
                        end else begin
                            ex = (src % FRAME) % HT;
                            ey = (src % FRAME) / HT;
                            pin_rgb = (ex < HA && ey < VA) ? vif.rgb_data : 12'h000;
                            pin_hs  = (ex >= HA + HFP && ex < HA + HFP + HSY) ? HPOL : ~HPOL;
                            pin_vs  = (ey >= VA + VFP && ey < VA + VFP + VSY) ? VPOL : ~VPOL;
                        end
                    end
                    t++;
                end
            end
        end

        #5;
        n_cmp++;
        if (pix_q.size() + gap_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pixel/%0d idle expectations left required=0/0", pix_q.size(), gap_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
